pi_controller_sat: RTL and testbench

PI_CONTROLLER_SAT -- requirements
Module: pi_controller_sat

---
 rtl/pi_controller_sat.sv | 108 ++++++++++
 tb/tb_pi_controller_sat.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pi_controller_sat.sv
// Two-stage pipelined PI controller with a saturating integrator and a clamped output.
// Define PI_CONTROLLER_SAT_ANTIWINDUP_EN to bound the integrator to the output range scaled by FRAC.
module pi_controller_sat #(
    parameter int W    = 32,
    parameter int KP   = 1,
    parameter int KI   = 1000,
    parameter int FRAC = 0,
    parameter logic signed [W-1:0] OUT_MAX = {1'b0, {(W-1){1'b1}}},
    parameter logic signed [W-1:0] OUT_MIN = {1'b1, {(W-1){1'b0}}}
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic signed [W-1:0] error,
    input  logic                clr,
    output logic signed [W-1:0] out,
    output logic                out_valid,
    output logic                sat
);

    localparam int PW = 2 * W;

    localparam logic signed [PW-1:0] KP_EXT = PW'(KP);
    localparam logic signed [PW-1:0] KI_EXT = PW'(KI);
    localparam logic signed [PW:0]   O_HI   = (PW+1)'(OUT_MAX);
    localparam logic signed [PW:0]   O_LO   = (PW+1)'(OUT_MIN);

`ifdef PI_CONTROLLER_SAT_ANTIWINDUP_EN
    // Integrator never exceeds what the output clamp could express after scaling.
    localparam logic signed [PW:0] I_HI = O_HI <<< FRAC;
    localparam logic signed [PW:0] I_LO = O_LO <<< FRAC;
`else
    localparam logic signed [PW:0] I_HI = {2'b00, {(PW-1){1'b1}}};
    localparam logic signed [PW:0] I_LO = {2'b11, {(PW-1){1'b0}}};
`endif

    logic signed [PW-1:0] p_reg;
    logic signed [PW-1:0] i_reg;
    logic                 v1;

    logic signed [PW-1:0] err_ext;
    logic signed [PW-1:0] p_next;
    logic signed [PW-1:0] ki_prod;
    logic signed [PW:0]   i_sum;
    logic signed [PW:0]   i_sat;
    logic signed [PW:0]   s_sum;
    logic signed [PW:0]   s_shift;
    logic signed [W-1:0]  o_next;
    logic                 o_sat;
    logic                 unused_bits;

    // Sums carry one guard bit so overflow is detected before clamping instead of wrapping.
    always_comb begin
        err_ext = {{W{error[W-1]}}, error};
        p_next  = err_ext * KP_EXT;
        ki_prod = err_ext * KI_EXT;
        i_sum   = {i_reg[PW-1], i_reg} + {ki_prod[PW-1], ki_prod};
        if (i_sum > I_HI) begin
            i_sat = I_HI;
        end else if (i_sum < I_LO) begin
            i_sat = I_LO;
        end else begin
            i_sat = i_sum;
        end

        s_sum   = {p_reg[PW-1], p_reg} + {i_reg[PW-1], i_reg};
        s_shift = s_sum >>> FRAC;
        o_next  = s_shift[W-1:0];
        o_sat   = 1'b0;
        if (s_shift > O_HI) begin
            o_next = OUT_MAX;
            o_sat  = 1'b1;
        end else if (s_shift < O_LO) begin
            o_next = OUT_MIN;
            o_sat  = 1'b1;
        end
    end

    assign unused_bits = ^{i_sat[PW], s_shift[PW:W]};

    always_ff @(posedge clk) begin
        if (rst) begin
            p_reg     <= '0;
            i_reg     <= '0;
            v1        <= 1'b0;
            out       <= '0;
            out_valid <= 1'b0;
            sat       <= 1'b0;
        end else begin
            if (clr) begin
                i_reg <= '0;
            end else if (in_valid) begin
                i_reg <= i_sat[PW-1:0];
            end
            if (in_valid) begin
                p_reg <= p_next;
            end
            v1        <= in_valid;
            out_valid <= v1;
            // Output and flag hold between samples so downstream sees the last command.
            if (v1) begin
                out <= o_next;
                sat <= o_sat;
            end
        end
    end

endmodule

// File: tb/tb_pi_controller_sat.sv
// Self-checking bench for pi_controller_sat using an arithmetic reference model of the PI law.
module tb_pi_controller_sat;

    localparam int     W    = 16;
    localparam int     KP   = 2;
    localparam int     KI   = 3;
    localparam int     FRAC = 1;
    localparam longint OMAX = 100;
    localparam longint OMIN = -100;
`ifdef PI_CONTROLLER_SAT_ANTIWINDUP_EN
    localparam longint I_HI = OMAX * (longint'(1) << FRAC);
    localparam longint I_LO = OMIN * (longint'(1) << FRAC);
`else
    localparam longint I_HI = (longint'(1) << (2*W-1)) - 1;
    localparam longint I_LO = -(longint'(1) << (2*W-1));
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic                clr = 1'b0;
    logic signed [W-1:0] error = '0;
    logic signed [W-1:0] out;
    logic                out_valid;
    logic                sat;

    int checks = 0;
    int passes = 0;

    longint mi;
    bit     pend_v;
    longint pend_o;
    bit     pend_s;
    bit     exp_valid;
    longint exp_out;
    bit     exp_sat;

    always #5 clk = ~clk;

    pi_controller_sat #(
        .W(W), .KP(KP), .KI(KI), .FRAC(FRAC),
        .OUT_MAX(16'(OMAX)), .OUT_MIN(16'(OMIN))
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .error(error), .clr(clr),
        .out(out), .out_valid(out_valid), .sat(sat)
    );

    function automatic longint floor_div(input longint a, input longint d);
        if (a >= 0) return a / d;
        return -((-a + d - 1) / d);
    endfunction

    function automatic longint limit(input longint v, input longint lo, input longint hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // One clock: drive inputs, then advance the model so exp_* describe the outputs after this edge.
    task automatic tick(input bit r, input bit v, input longint e, input bit c);
        longint s;
        rst = r; in_valid = v; error = 16'(e); clr = c;
        @(posedge clk);
        #1;
        if (r) begin
            exp_valid = 0; exp_out = 0; exp_sat = 0;
            mi = 0; pend_v = 0; pend_o = 0; pend_s = 0;
        end else begin
            exp_valid = pend_v; exp_out = pend_o; exp_sat = pend_s;
            if (c) mi = 0;
            else if (v) mi = limit(mi + e * KI, I_LO, I_HI);
            if (v) begin
                s = floor_div(e * KP + mi, longint'(1) << FRAC);
                pend_o = limit(s, OMIN, OMAX);
                pend_s = (s > OMAX) || (s < OMIN);
            end
            pend_v = v;
        end
    endtask

    task automatic test_reset();
        tick(1, 1, 55, 1);
        tick(1, 0, 0, 0);
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); else passes++;
        checks++; if (out !== 16'sd0) $display("[TB] FAIL reset_out: got %0d expected 0", out); else passes++;
        checks++; if (sat !== 1'b0) $display("[TB] FAIL reset_sat: got %b expected 0", sat); else passes++;
    endtask

    task automatic test_single();
        tick(1, 0, 0, 0);
        tick(0, 1, 10, 0);
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL single_early_valid: got %b expected 0", out_valid); else passes++;
        tick(0, 0, 0, 0);
        checks++; if (out_valid !== 1'b1) $display("[TB] FAIL single_valid: got %b expected 1", out_valid); else passes++;
        checks++; if (out !== 16'sd25) $display("[TB] FAIL single_out: got %0d expected 25", out); else passes++;
        checks++; if (sat !== 1'b0) $display("[TB] FAIL single_sat: got %b expected 0", sat); else passes++;
        tick(0, 0, 0, 0);
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL single_pulse: got %b expected 0", out_valid); else passes++;
        checks++; if (out !== 16'sd25) $display("[TB] FAIL single_hold: got %0d expected 25", out); else passes++;
    endtask

    task automatic test_negative();
        tick(1, 0, 0, 0);
        tick(0, 1, -3, 0);
        tick(0, 0, 0, 0);
        checks++; if (out !== -16'sd8) $display("[TB] FAIL negative_out: got %0d expected -8", out); else passes++;
        checks++; if (sat !== 1'b0) $display("[TB] FAIL negative_sat: got %b expected 0", sat); else passes++;
    endtask

    task automatic test_back_to_back();
        tick(1, 0, 0, 0);
        for (int i = 0; i < 13; i++) begin
            tick(0, 1, (i < 12) ? 10 : -10, 0);
            checks++; if (out_valid !== exp_valid) $display("[TB] FAIL ramp_valid[%0d]: got %b expected %b", i, out_valid, exp_valid); else passes++;
            checks++; if (out !== 16'(exp_out)) $display("[TB] FAIL ramp_out[%0d]: got %0d expected %0d", i, out, exp_out); else passes++;
            checks++; if (sat !== exp_sat) $display("[TB] FAIL ramp_sat[%0d]: got %b expected %b", i, sat, exp_sat); else passes++;
        end
        tick(0, 0, 0, 0);
`ifdef PI_CONTROLLER_SAT_ANTIWINDUP_EN
        checks++; if (out !== 16'sd75) $display("[TB] FAIL unwind_out: got %0d expected 75", out); else passes++;
        checks++; if (sat !== 1'b0) $display("[TB] FAIL unwind_sat: got %b expected 0", sat); else passes++;
`else
        checks++; if (out !== 16'sd100) $display("[TB] FAIL unwind_out: got %0d expected 100", out); else passes++;
        checks++; if (sat !== 1'b1) $display("[TB] FAIL unwind_sat: got %b expected 1", sat); else passes++;
`endif
    endtask

    task automatic test_clear();
        tick(1, 0, 0, 0);
        repeat (3) tick(0, 1, 10, 0);
        tick(0, 1, 10, 1);
        tick(0, 0, 0, 0);
        checks++; if (out !== 16'sd10) $display("[TB] FAIL clear_out: got %0d expected 10", out); else passes++;
        tick(0, 1, 10, 0);
        tick(0, 0, 0, 0);
        checks++; if (out !== 16'sd25) $display("[TB] FAIL clear_next_out: got %0d expected 25", out); else passes++;
    endtask

    task automatic test_reset_inflight();
        tick(1, 0, 0, 0);
        tick(0, 1, 10, 0);
        tick(0, 1, 20, 0);
        tick(1, 0, 0, 0);
        checks++; if (out !== 16'sd0) $display("[TB] FAIL inflight_out: got %0d expected 0", out); else passes++;
        checks++; if (sat !== 1'b0) $display("[TB] FAIL inflight_sat: got %b expected 0", sat); else passes++;
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 0, 0);
            checks++; if (out_valid !== 1'b0) $display("[TB] FAIL inflight_valid[%0d]: got %b expected 0", i, out_valid); else passes++;
        end
    endtask

    task automatic test_random();
        bit     r, v, c;
        longint e;
        tick(1, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 60) == 0);
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 15) == 0);
            e = longint'($urandom_range(0, 120)) - 60;
            if ($urandom_range(0, 20) == 0) e = e * 400;
            tick(r, v, e, c);
            checks++; if (out_valid !== exp_valid) $display("[TB] FAIL random_valid[%0d]: got %b expected %b", i, out_valid, exp_valid); else passes++;
            checks++; if (out !== 16'(exp_out)) $display("[TB] FAIL random_out[%0d]: got %0d expected %0d", i, out, exp_out); else passes++;
            checks++; if (sat !== exp_sat) $display("[TB] FAIL random_sat[%0d]: got %b expected %b", i, sat, exp_sat); else passes++;
        end
    endtask

    task automatic test_integrator_limit();
        tick(1, 0, 0, 0);
        repeat (22000) tick(0, 1, 32767, 0);
        tick(0, 1, -32767, 0);
        tick(0, 0, 0, 0);
        checks++; if (out !== 16'(exp_out)) $display("[TB] FAIL ilimit_out: got %0d expected %0d", out, exp_out); else passes++;
        checks++; if (sat !== exp_sat) $display("[TB] FAIL ilimit_sat: got %b expected %b", sat, exp_sat); else passes++;
        repeat (3) tick(0, 1, -32767, 0);
        tick(0, 0, 0, 0);
        checks++; if (out !== 16'(exp_out)) $display("[TB] FAIL ilimit_unwind_out: got %0d expected %0d", out, exp_out); else passes++;
    endtask

    initial begin
        mi = 0; pend_v = 0; pend_o = 0; pend_s = 0;
        exp_valid = 0; exp_out = 0; exp_sat = 0;
        test_reset();
        test_single();
        test_negative();
        test_back_to_back();
        test_clear();
        test_reset_inflight();
        test_random();
        test_integrator_limit();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
